// File: rtl/sayac_mem_responder_if.sv
// sayac_mem_responder_if: SAYAC core memory bus (address, write data, request levels, read data, ready, error)
interface sayac_mem_responder_if;
  logic [15:0] addrBus;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic readMEM;
  logic writeMEM;
  logic readyMEM;
  logic errMEM;
  modport master(output addrBus, dataIn, readMEM, writeMEM, input dataOut, readyMEM, errMEM);
  modport slave(input addrBus, dataIn, readMEM, writeMEM, output dataOut, readyMEM, errMEM);
endinterface

// File: rtl/sayac_mem_responder.sv
// sayac_mem_responder: SAYAC bus memory responder with wait states; ports clk, rst (sync active-low), bus (slave side of sayac_mem_responder_if)
module sayac_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT = 2
) (
  input logic clk,
  input logic rst,
  sayac_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [15:0] addr, data, dout;
  logic rd, wr, err, req, done, in_range, bad;
  logic [15:0] mem [2**ADDR_W];
  assign req = bus.readMEM | bus.writeMEM;
  assign done = state == BUSY && cnt == 4'd0;
  assign in_range = (addr >> ADDR_W) == 16'd0;
  assign bad = (rd & wr) | !in_range;
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (req ? BUSY : IDLE) :
              state == BUSY ? (cnt == 4'd0 ? RESP : BUSY) :
              state == RESP ? RELEASE : (req ? RELEASE : IDLE);
  always_comb begin
    bus.readyMEM = state == RESP;
    bus.errMEM = state == RESP && err;
    bus.dataOut = dout;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= 4'd0;
      dout <= 16'h0;
      err <= 1'b0;
      addr <= 16'h0;
      data <= 16'h0;
      rd <= 1'b0;
      wr <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        addr <= bus.addrBus;
        data <= bus.dataIn;
        rd <= bus.readMEM;
        wr <= bus.writeMEM;
        cnt <= 4'(WAIT);
      end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (done) begin
        err <= bad;
        if (rd && !wr) dout <= in_range ? mem[addr[ADDR_W-1:0]] : 16'h0;
      end
    end
  // RAM has no reset; gating on rst keeps an aborted write from committing
  always_ff @(posedge clk)
    if (rst && done && wr && !bad) mem[addr[ADDR_W-1:0]] <= data;
endmodule

// File: tb/tb_sayac_mem_responder.sv
// tb_sayac_mem_responder: directed tests for sayac_mem_responder with WAIT=2 and WAIT=0 instances
module tb_sayac_mem_responder;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  sayac_mem_responder_if b2();
  sayac_mem_responder_if b0();
  sayac_mem_responder #(.ADDR_W(10), .WAIT(2)) u2(.clk(clk), .rst(rst), .bus(b2.slave));
  sayac_mem_responder #(.ADDR_W(10), .WAIT(0)) u0(.clk(clk), .rst(rst), .bus(b0.slave));
  always #5 clk = ~clk;

  task automatic drive(input bit z, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (z) begin
      b0.readMEM = r; b0.writeMEM = w; b0.addrBus = a; b0.dataIn = d;
    end else begin
      b2.readMEM = r; b2.writeMEM = w; b2.addrBus = a; b2.dataIn = d;
    end
  endtask

  function automatic logic rdy(input bit z);
    return z ? b0.readyMEM : b2.readyMEM;
  endfunction
  function automatic logic erv(input bit z);
    return z ? b0.errMEM : b2.errMEM;
  endfunction
  function automatic logic [15:0] dout(input bit z);
    return z ? b0.dataOut : b2.dataOut;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full handshake. lat = edges from request sample to readyMEM (-1 on timeout);
  // stray flags errMEM without readyMEM or a second readyMEM pulse.
  task automatic access(input bit z, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit chg, input logic [15:0] ca, input logic [15:0] cd,
                        output int lat, output logic [15:0] q, output logic e, output bit stray);
    drive(z, r, w, a, d);
    lat = -1; q = 16'hxxxx; e = 1'bx; stray = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (i == 1 && chg) drive(z, r, w, ca, cd);
      if (rdy(z)) begin
        lat = i; q = dout(z); e = erv(z);
      end else if (erv(z)) stray = 1;
    end
    drive(z, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rdy(z) || erv(z)) stray = 1;
    end
  endtask

  int lat;
  logic [15:0] q;
  logic e;
  bit s;

  task automatic test_reset;
    drive(0, 1, 0, 16'h0, 16'h0);
    drive(1, 1, 0, 16'h0, 16'h0);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b2.dataOut !== 16'h0 || b2.readyMEM !== 1'b0 || b2.errMEM !== 1'b0 ||
          b0.dataOut !== 16'h0 || b0.readyMEM !== 1'b0 || b0.errMEM !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h/%b/%b %h/%b/%b want 0/0/0", i,
                 b2.dataOut, b2.readyMEM, b2.errMEM, b0.dataOut, b0.readyMEM, b0.errMEM);
      end
    end
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    rst = 1;
    tick();
    access(0, 1, 0, 16'h0001, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || s) begin errors++; $display("FAIL reset_idle_latency got %0d stray %0d want 4 0", lat, s); end
  endtask

  task automatic test_write_read;
    access(0, 0, 1, 16'h0012, 16'hA5C3, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || e !== 1'b0 || s) begin errors++; $display("FAIL wr_a5c3 got lat %0d err %b stray %0d want 4 0 0", lat, e, s); end
    access(0, 1, 0, 16'h0012, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || q !== 16'hA5C3 || e !== 1'b0 || s) begin errors++; $display("FAIL rd_a5c3 got lat %0d data %h err %b want 4 a5c3 0", lat, q, e); end
    checks++;
    if (b2.dataOut !== 16'hA5C3) begin errors++; $display("FAIL rd_hold got %h want a5c3", b2.dataOut); end
  endtask

  task automatic test_held;
    int n, first;
    access(1, 0, 1, 16'h0007, 16'h7777, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 2 || e !== 1'b0 || s) begin errors++; $display("FAIL w0_write got lat %0d err %b want 2 0", lat, e); end
    access(1, 0, 1, 16'h03FF, 16'h0BEE, 0, 0, 0, lat, q, e, s);
    drive(1, 1, 0, 16'h0007, 16'h0);
    n = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (b0.readyMEM) begin
        n++;
        if (first < 0) first = i;
        if (b0.dataOut !== 16'h7777) begin checks++; errors++; $display("FAIL held_data got %h want 7777", b0.dataOut); end
      end
      if (i == 2) b0.addrBus = 16'h03FF;
      if (i == 5) drive(1, 0, 0, 16'h0, 16'h0);
    end
    checks++;
    if (n !== 1 || first !== 2) begin errors++; $display("FAIL held_single_pulse got %0d pulses first %0d want 1 at 2", n, first); end
    access(1, 1, 0, 16'h03FF, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 2 || q !== 16'h0BEE || e !== 1'b0 || s) begin errors++; $display("FAIL rd_03ff got lat %0d data %h err %b want 2 0bee 0", lat, q, e); end
  endtask

  task automatic test_errors;
    access(0, 0, 1, 16'h0000, 16'h1111, 0, 0, 0, lat, q, e, s);
    access(0, 0, 1, 16'h0400, 16'hFFFF, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || e !== 1'b1 || s) begin errors++; $display("FAIL oor_write got lat %0d err %b want 4 1", lat, e); end
    access(0, 1, 0, 16'h0000, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (q !== 16'h1111 || e !== 1'b0) begin errors++; $display("FAIL oor_no_alias got %h err %b want 1111 0", q, e); end
    access(0, 1, 0, 16'h8000, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (q !== 16'h0000 || e !== 1'b1 || s) begin errors++; $display("FAIL oor_read got %h err %b want 0000 1", q, e); end
    access(0, 1, 0, 16'h0012, 16'h0, 0, 0, 0, lat, q, e, s);
    access(0, 1, 1, 16'h0012, 16'h0BAD, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || e !== 1'b1 || q !== 16'hA5C3 || s) begin errors++; $display("FAIL illegal got lat %0d err %b data %h want 4 1 a5c3", lat, e, q); end
    access(0, 1, 0, 16'h0012, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (q !== 16'hA5C3 || e !== 1'b0) begin errors++; $display("FAIL illegal_no_write got %h err %b want a5c3 0", q, e); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    access(0, 0, 1, 16'h0005, 16'h5555, 0, 0, 0, lat, q, e, s);
    drive(0, 0, 1, 16'h0005, 16'h1234);
    tick();
    tick();
    rst = 0;
    drive(0, 0, 0, 16'h0, 16'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) rst = 1;
      if (b2.readyMEM || b2.errMEM) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_ready got ready 1 want 0"); end
    checks++;
    if (b2.dataOut !== 16'h0) begin errors++; $display("FAIL abort_dout got %h want 0000", b2.dataOut); end
    access(0, 1, 0, 16'h0005, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (lat !== 4 || q !== 16'h5555 || e !== 1'b0) begin errors++; $display("FAIL abort_no_commit got lat %0d data %h want 4 5555", lat, q); end
  endtask

  task automatic test_busy_change;
    access(0, 0, 1, 16'h0021, 16'h0000, 0, 0, 0, lat, q, e, s);
    access(0, 0, 1, 16'h0020, 16'hCAFE, 1, 16'h0021, 16'hDEAD, lat, q, e, s);
    checks++;
    if (lat !== 4 || e !== 1'b0 || s) begin errors++; $display("FAIL busy_write got lat %0d err %b want 4 0", lat, e); end
    access(0, 1, 0, 16'h0020, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (q !== 16'hCAFE) begin errors++; $display("FAIL busy_latched got %h want cafe", q); end
    access(0, 1, 0, 16'h0021, 16'h0, 0, 0, 0, lat, q, e, s);
    checks++;
    if (q !== 16'h0000) begin errors++; $display("FAIL busy_other got %h want 0000", q); end
  endtask

  initial begin
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    test_reset();
    test_write_read();
    test_held();
    test_errors();
    test_reset_mid();
    test_busy_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
